// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the device over the shared open-drain ps2_clk/ps2_data
// pair. It holds rx_inhibit high so the receive path ignores the frame while it is
// in flight.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | lines released, tx_ready high, waiting for tx_valid
// S_INHIBIT    | ps2_clk held low; start bit (data low) asserted in last cycle
// S_SEND       | clock released; device clocks out d0..d7, parity, stop, ACK
// S_WAIT_IDLE  | ACK seen; waiting for both lines to return high
// S_DONE       | one-cycle done pulse
// S_ERR        | one-cycle err pulse (watchdog expired or ACK missing)
//
// One counter is shared. In S_INHIBIT it times the inhibit phase. In S_SEND and
// S_WAIT_IDLE it is the watchdog. Both uses count down to a terminal count of
// zero, so 2^CNT_W must exceed max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err
);

    // Each load value is one less than its duration: the terminal-count cycle
    // (cnt == 0) is itself part of the phase.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [7:0]       shreg, shreg_n;
    logic             parity, parity_n;
    logic             data_oe_q, data_oe_n;

    logic             clk_s1, clk_s2, clk_prev;
    logic             data_s1, data_s2;
    logic             fe;

    // Two-flop synchronisers on both lines plus a delayed copy of the clock for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    // The inhibit phase drives the clock line low itself, so fe also fires in the
    // first few S_INHIBIT cycles. The FSM ignores fe in that state.
    assign fe = clk_prev & ~clk_s2;

    // FSM state register together with the frame datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            parity    <= parity_n;
            data_oe_q <= data_oe_n;
        end
    end

    // Next-state logic, watchdog/inhibit counting and data-line updates on each falling edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        parity_n  = parity;
        data_oe_n = data_oe_q;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_n   = tx_data;
                    parity_n  = ~^tx_data;
                    cnt_n     = INHIBIT_LOAD;
                    bitcnt_n  = '0;
                    // With a one-cycle inhibit, the start bit has to go out immediately.
                    data_oe_n = (INHIBIT_CYCLES == 1);
                    state_n   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt == CNT_ZERO) begin
                    cnt_n    = TIMEOUT_LOAD;
                    bitcnt_n = '0;
                    state_n  = S_SEND;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    // The start bit goes low during the final inhibit cycle, so data
                    // is already low when the clock is released.
                    if (cnt == CNT_ONE) begin
                        data_oe_n = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (cnt == CNT_ZERO) begin
                    data_oe_n = 1'b0;
                    state_n   = S_ERR;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    if (fe) begin
                        bitcnt_n = bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            data_oe_n = ~shreg[bitcnt[2:0]];
                        end else if (bitcnt == 4'd8) begin
                            data_oe_n = ~parity;
                        end else if (bitcnt == 4'd9) begin
                            data_oe_n = 1'b0;
                        end else begin
                            data_oe_n = 1'b0;
                            state_n   = data_s2 ? S_ERR : S_WAIT_IDLE;
                        end
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (cnt == CNT_ZERO) begin
                    state_n = S_ERR;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                    if (clk_s2 && data_s2) begin
                        state_n = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            S_ERR: begin
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end

            default: begin
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    // All outputs are decoded directly from the state and the registered data-line enable.
    always_comb begin
        tx_ready    = (state == S_IDLE);
        rx_inhibit  = (state != S_IDLE);
        ps2_clk_oe  = (state == S_INHIBIT);
        ps2_data_oe = data_oe_q;
        done        = (state == S_DONE);
        err         = (state == S_ERR);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx. A behavioural PS/2 device clocks the frame out,
// and the expected line bits and outcome pulses are queued when each request is made.

module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, err;
    logic       ps2_clk_in, ps2_data_in;

    // Open-drain wired-AND of the host and the device.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    int checks = 0;
    int errors = 0;

    bit         exp_bits[$];
    logic [1:0] exp_out[$];
    logic [1:0] obs_out[$];
    int         consec = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic       prev_pulse = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_inhibit(rx_inhibit),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Record every done/err pulse as {done, err}.
    always @(negedge clk) begin
        if (reset) begin
            prev_pulse <= 1'b0;
        end else begin
            if ((done || err) && prev_pulse) consec <= consec + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (done || err) obs_out.push_back({done, err});
            prev_pulse <= done || err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_outcome(input string tag);
        int n = 0;
        while (obs_out.size() == 0 && n < 300) begin
            tick(1);
            n++;
        end
        if (obs_out.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no done/err pulse within 300 cycles, expected one", tag);
            if (exp_out.size() > 0) void'(exp_out.pop_front());
        end else begin
            check(tag, obs_out.pop_front(), exp_out.pop_front());
        end
    endtask

    // mode 0: device clocks and ACKs; 1: 11 clocks but no ACK; 2: device silent;
    // 3: reset asserted once bitcnt reaches 4.
    task automatic send(input logic [7:0] b, input int mode, input string tag);
        int   n;
        logic first_doe;
        logic last_doe;

        if (mode != 2) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
            exp_bits.push_back(~^b);
            exp_bits.push_back(1'b1);
        end
        if (mode == 0) exp_out.push_back(2'b10);
        else if (mode == 1 || mode == 2) exp_out.push_back(2'b01);

        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = ~b;
        check({tag, "/tx_ready_drop"}, tx_ready, 0);
        check({tag, "/rx_inhibit"}, rx_inhibit, 1);

        n = 0;
        first_doe = ps2_data_oe;
        last_doe = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < INHIBIT + 10) begin
            last_doe = ps2_data_oe;
            n++;
            tick(1);
        end
        check({tag, "/inhibit_len"}, n, INHIBIT);
        check({tag, "/start_early"}, first_doe, 0);
        check({tag, "/start_before_release"}, last_doe, 1);

        if (mode == 2) begin
            n = 0;
            while (err !== 1'b1 && n < TIMEOUT + 50) begin
                n++;
                tick(1);
            end
            check({tag, "/timeout_len"}, n, TIMEOUT);
            check({tag, "/err_clk_oe"}, ps2_clk_oe, 0);
            check({tag, "/err_data_oe"}, ps2_data_oe, 0);
            wait_outcome({tag, "/outcome"});
            return;
        end

        tick(4);
        check({tag, "/start_bit"}, ps2_data_in, 0);

        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode == 0) begin
                dev_data = 1'b0;
                tick(4);
            end
            dev_clk = 1'b0;
            tick(HALF);
            dev_clk = 1'b1;
            if (k <= 10) check($sformatf("%s/bit%0d", tag, k - 1), ps2_data_in, exp_bits.pop_front());
            tick(HALF);
            if (mode == 3 && k == 4) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                check({tag, "/rst_clk_oe"}, ps2_clk_oe, 0);
                check({tag, "/rst_data_oe"}, ps2_data_oe, 0);
                check({tag, "/rst_rx_inhibit"}, rx_inhibit, 0);
                check({tag, "/rst_tx_ready"}, tx_ready, 1);
                exp_bits.delete();
                tick(20);
                check({tag, "/no_pulse"}, obs_out.size(), 0);
                return;
            end
        end
        dev_data = 1'b1;
        wait_outcome({tag, "/outcome"});
        tick(2);
        check({tag, "/tx_ready_back"}, tx_ready, 1);
    endtask

    initial begin
        tick(3);
        check("reset/tx_ready", tx_ready, 1);
        check("reset/clk_oe", ps2_clk_oe, 0);
        check("reset/data_oe", ps2_data_oe, 0);
        check("reset/rx_inhibit", rx_inhibit, 0);
        check("reset/done", done, 0);
        check("reset/err", err, 0);
        reset = 1'b0;
        tick(5);

        send(8'hED, 0, "ed");
        tick(5);
        send(8'h07, 0, "x07");
        tick(5);
        send(8'h00, 0, "x00");
        tick(5);
        send(8'hA5, 2, "timeout");
        tick(5);
        send(8'h3C, 1, "noack");
        tick(60);
        send(8'h5A, 3, "abort");
        tick(5);
        send(8'hF4, 0, "f4");
        tick(10);

        check("total_done", done_cnt, 4);
        check("total_err", err_cnt, 2);
        check("consecutive_pulses", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
